// File: rtl/dtr_out_check.sv
// Output-side checker for the double-time-redundant datapath: compares the two
// consecutive copies of each result word, commits matches, flags mismatches.
module dtr_out_check #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             substr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fatal
);

  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  phase_t           ph, ph_nxt;
  logic [WIDTH-1:0] copy_a;
  logic [RW-1:0]    retry, retry_inc;
  logic             cap, cmp, match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ph <= PH_A;
    else        ph <= ph_nxt;
  end

  // substr forces the next cycle back to copy A, resynchronising the pair
  always_comb begin
    ph_nxt    = ph;
    cap       = 1'b0;
    cmp       = 1'b0;
    match     = (din == copy_a);
    retry_inc = (retry == RW'(MAX_RETRY)) ? retry : retry + RW'(1);
    if (substr) begin
      ph_nxt = PH_A;
    end else begin
      case (ph)
        PH_A: begin
          cap    = 1'b1;
          ph_nxt = PH_B;
        end
        PH_B: begin
          cmp    = 1'b1;
          ph_nxt = PH_A;
        end
        default: ph_nxt = PH_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      copy_a     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      fail       <= 1'b0;
      err_cnt    <= '0;
      retry      <= '0;
      fatal      <= 1'b0;
    end else begin
      dout_valid <= cmp && match;
      fail       <= cmp && !match;
      if (cap) copy_a <= din;
      if (cmp && match) begin
        dout  <= din;
        retry <= '0;
      end
      if (cmp && !match) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        retry <= retry_inc;
        if (retry_inc == RW'(MAX_RETRY)) fatal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dtr_out_check.sv
// Randomized and directed bench for dtr_out_check against a pair-level reference model.
module tb_dtr_out_check;

  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       substr = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout, dout2;
  logic       dout_valid, dout_valid2, fail, fail2, fatal, fatal2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  dtr_out_check #(.WIDTH(8), .CNT_W(8), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .din(din), .substr(substr),
    .dout(dout), .dout_valid(dout_valid), .fail(fail),
    .err_cnt(err_cnt), .fatal(fatal)
  );

  dtr_out_check #(.WIDTH(8), .CNT_W(2), .MAX_RETRY(MR)) dut_sat (
    .clk(clk), .reset(reset), .din(din), .substr(substr),
    .dout(dout2), .dout_valid(dout_valid2), .fail(fail2),
    .err_cnt(err_cnt2), .fatal(fatal2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words arrive in pairs counted from the last resync point
  int         m_slot;
  logic [7:0] m_a, m_dout;
  logic       m_valid, m_fail, m_fatal;
  int         m_errs, m_run;

  function automatic void model_reset();
    m_slot = 0; m_a = '0; m_dout = '0; m_valid = 0; m_fail = 0;
    m_fatal = 0; m_errs = 0; m_run = 0;
  endfunction

  function automatic void model_edge(logic [7:0] d, logic s);
    m_valid = 0;
    m_fail  = 0;
    if (s) begin
      m_slot = 0;
    end else begin
      if (m_slot % 2 == 0) m_a = d;
      else if (d == m_a) begin
        m_dout = d; m_valid = 1; m_run = 0;
      end else begin
        m_fail = 1; m_errs++; m_run++;
        if (m_run >= MR) m_fatal = 1;
      end
      m_slot++;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("dout",       32'(dout),        32'(m_dout));
    check("dout_valid", 32'(dout_valid),  32'(m_valid));
    check("fail",       32'(fail),        32'(m_fail));
    check("err_cnt",    32'(err_cnt),     (m_errs > 255) ? 32'd255 : 32'(m_errs));
    check("fatal",      32'(fatal),       32'(m_fatal));
    check("dout_s",     32'(dout2),       32'(m_dout));
    check("valid_s",    32'(dout_valid2), 32'(m_valid));
    check("fail_s",     32'(fail2),       32'(m_fail));
    check("err_cnt_s",  32'(err_cnt2),    (m_errs > 3) ? 32'd3 : 32'(m_errs));
    check("fatal_s",    32'(fatal2),      32'(m_fatal));
  endtask

  // Inputs change one time unit after the edge; outputs are sampled at the same point
  task automatic step(input logic [7:0] d, input logic s);
    din    = d;
    substr = s;
    @(posedge clk);
    #1;
    model_edge(d, s);
    check_outputs();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_outputs();
    reset = 1'b1;

    // clean stream
    step(8'h11, 0); step(8'h11, 0);
    check("t1_dout1", 32'(dout), 32'h11);
    step(8'h22, 0); step(8'h22, 0);
    check("t1_dout2", 32'(dout), 32'h22);

    // single mismatch
    step(8'h5A, 0); step(8'h5B, 0);
    check("t2_fail", 32'(fail), 32'd1);
    check("t2_dout", 32'(dout), 32'h22);
    check("t2_err",  32'(err_cnt), 32'd1);

    // substitution window mid-pair
    step(8'h33, 0);
    for (int i = 0; i < 4; i++) step(8'($urandom), 1);
    step(8'h44, 0); step(8'h44, 0);
    check("t3_dout", 32'(dout), 32'h44);

    // substr collides with a mismatching compare
    step(8'h30, 0); step(8'h31, 1);
    check("t4_fail", 32'(fail), 32'd0);
    check("t4_err",  32'(err_cnt), 32'd1);

    // fatal after three consecutive failed checks; reset dropped mid-pair first
    step(8'h77, 0);
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'(8'h60 + i), 0); step(8'(8'h90 + i), 0);
    end
    check("t5_fatal", 32'(fatal), 32'd1);
    step(8'h55, 0); step(8'h55, 0);
    check("t5_commit", 32'(dout), 32'h55);
    check("t5_sticky", 32'(fatal), 32'd1);

    // two fails, commit, two fails: no fatal
    step(8'h01, 0);
    mid_reset();
    step(8'h01, 0); step(8'h02, 0);
    step(8'h03, 0); step(8'h04, 0);
    step(8'hAA, 0); step(8'hAA, 0);
    step(8'h05, 0); step(8'h06, 0);
    step(8'h07, 0); step(8'h08, 0);
    check("t5b_fatal", 32'(fatal), 32'd0);
    step(8'h09, 0); step(8'h0A, 0);
    check("t6_err",     32'(err_cnt),  32'd5);
    check("t6_err_sat", 32'(err_cnt2), 32'd3);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic       s;
      logic [7:0] d;
      s = ($urandom_range(0, 9) == 0);
      if ((m_slot % 2 == 1) && ($urandom_range(0, 3) != 0)) d = m_a;
      else d = 8'($urandom);
      step(d, s);
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
